// File: rtl/pheap_level_engine.sv
// One heap-level step engine for a pipelined min-heap: reads a node and its two
// children, writes the node back and either finishes or forwards an item downward.
module pheap_level_engine #(
  parameter int LEVEL  = 2,
  parameter int LEVELS = 4,
  parameter int KEY_W  = 16,
  parameter int VAL_W  = 16,
  localparam int KV_W  = KEY_W + VAL_W,
  localparam int CNT_W = LEVELS,
  localparam int ENT_W = 1 + CNT_W + KV_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         op,
  input  logic [KV_W-1:0]    in,
  input  logic [LEVEL-2:0]   startPos,
  input  logic [ENT_W-1:0]   rTop,
  input  logic [ENT_W-1:0]   rBotL,
  input  logic [ENT_W-1:0]   rBotR,
  output logic [LEVEL-2:0]   raddrTop,
  output logic [LEVEL-2:0]   raddrBot,
  output logic               wenTop,
  output logic [LEVEL-2:0]   wraddrTop,
  output logic [ENT_W-1:0]   wData,
  output logic               active,
  output logic [1:0]         done,
  output logic [KV_W-1:0]    out,
  output logic [LEVEL-1:0]   endPos
);
  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE} state_t;

  localparam logic [1:0] OP_FREE = 2'd0, OP_LENQ = 2'd1, OP_LDEQ = 2'd2, OP_LREPL = 2'd3;
  localparam logic [1:0] D_IDLE = 2'd0, D_BUSY = 2'd1, D_DONE = 2'd2, D_NEXT = 2'd3;
  localparam int SUB_I = (1 << (LEVELS - LEVEL)) - 1;
  localparam logic [CNT_W:0] SUB_S = (CNT_W+1)'(SUB_I);

  state_t              state_q, state_d;
  logic [1:0]          op_q, op_d, done_q, done_d;
  logic [KV_W-1:0]     in_q, in_d;
  logic [LEVEL-2:0]    pos_q, pos_d, raddr_q, raddr_d, wraddr_q, wraddr_d;
  logic                active_q, active_d, wen_q, wen_d;

  // Entry field decode: valid | cnt | key | value
  logic              top_v, l_v, r_v;
  logic [CNT_W-1:0]  top_cnt, l_cnt, r_cnt;
  logic [KEY_W-1:0]  top_key, l_key, r_key, in_key, pick_key;
  logic [KV_W-1:0]   top_kv, l_kv, r_kv, pick_kv;
  logic [CNT_W:0]    occ_l, occ_r;
  logic              pick_r, any_child;

  assign top_v   = rTop[ENT_W-1];
  assign l_v     = rBotL[ENT_W-1];
  assign r_v     = rBotR[ENT_W-1];
  assign top_cnt = rTop[ENT_W-2 -: CNT_W];
  assign l_cnt   = rBotL[ENT_W-2 -: CNT_W];
  assign r_cnt   = rBotR[ENT_W-2 -: CNT_W];
  assign top_kv  = rTop[KV_W-1:0];
  assign l_kv    = rBotL[KV_W-1:0];
  assign r_kv    = rBotR[KV_W-1:0];
  assign top_key = top_kv[KV_W-1 -: KEY_W];
  assign l_key   = l_kv[KV_W-1 -: KEY_W];
  assign r_key   = r_kv[KV_W-1 -: KEY_W];
  assign in_key  = in_q[KV_W-1 -: KEY_W];

  assign occ_l = {1'b0, l_cnt} + (CNT_W+1)'(l_v);
  assign occ_r = {1'b0, r_cnt} + (CNT_W+1)'(r_v);

  // Smaller valid child wins; ties and an invalid right child go left
  assign pick_r    = r_v && (!l_v || (r_key < l_key));
  assign pick_kv   = pick_r ? r_kv : l_kv;
  assign pick_key  = pick_kv[KV_W-1 -: KEY_W];
  assign any_child = l_v | r_v;

  logic [ENT_W-1:0] wdata_w;
  logic [KV_W-1:0]  out_w;
  logic             dir_w;
  logic [1:0]       done_w;

  always_comb begin
    wdata_w = '0;
    out_w   = '0;
    dir_w   = 1'b0;
    done_w  = D_DONE;
    case (op_q)
      OP_LENQ: begin
        if (!top_v) begin
          wdata_w = {1'b1, {CNT_W{1'b0}}, in_q};
        end else if (occ_l >= SUB_S && occ_r >= SUB_S) begin
          // Subtree already full: leave node intact and drop the item
          wdata_w = rTop;
        end else begin
          dir_w  = (occ_l >= SUB_S);
          done_w = D_NEXT;
          if (in_key < top_key) begin
            wdata_w = {1'b1, top_cnt + CNT_W'(1), in_q};
            out_w   = top_kv;
          end else begin
            wdata_w = {1'b1, top_cnt + CNT_W'(1), top_kv};
            out_w   = in_q;
          end
        end
      end
      OP_LDEQ: begin
        if (any_child) begin
          wdata_w = {1'b1, top_cnt - CNT_W'(1), pick_kv};
          dir_w   = pick_r;
          done_w  = D_NEXT;
        end
      end
      OP_LREPL: begin
        if (any_child && (pick_key < in_key)) begin
          wdata_w = {1'b1, top_cnt, pick_kv};
          out_w   = in_q;
          dir_w   = pick_r;
          done_w  = D_NEXT;
        end else begin
          wdata_w = {1'b1, top_cnt, in_q};
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    in_d    = in_q;
    pos_d   = pos_q;
    done_d  = done_q;
    case (state_q)
      S_IDLE: begin
        if (start && op != OP_FREE) begin
          state_d = S_READ;
          op_d    = op;
          in_d    = in;
          pos_d   = startPos;
        end
      end
      S_READ:  state_d = S_WRITE;
      S_WRITE: begin
        state_d = S_IDLE;
        done_d  = D_DONE;
      end
      default: state_d = S_IDLE;
    endcase
    active_d = (state_d != S_IDLE);
    wen_d    = (state_d == S_WRITE);
    raddr_d  = (state_d == S_READ)  ? pos_d : '0;
    wraddr_d = (state_d == S_WRITE) ? pos_d : '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= OP_FREE;
      in_q     <= '0;
      pos_q    <= '0;
      done_q   <= D_IDLE;
      active_q <= 1'b0;
      wen_q    <= 1'b0;
      raddr_q  <= '0;
      wraddr_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      in_q     <= in_d;
      pos_q    <= pos_d;
      done_q   <= done_d;
      active_q <= active_d;
      wen_q    <= wen_d;
      raddr_q  <= raddr_d;
      wraddr_q <= wraddr_d;
    end
  end

  assign raddrTop  = raddr_q;
  assign raddrBot  = raddr_q;
  assign wenTop    = wen_q;
  assign wraddrTop = wraddr_q;
  assign active    = active_q;
  assign wData     = wen_q ? wdata_w : '0;
  assign out       = wen_q ? out_w : '0;
  assign endPos    = wen_q ? {pos_q, dir_w} : '0;
  assign done      = (state_q == S_READ)  ? D_BUSY :
                     (state_q == S_WRITE) ? done_w : done_q;
endmodule

// File: tb/tb_pheap_level_engine.sv
// Bench for pheap_level_engine at LEVEL=2, LEVELS=3: vector table with an
// expectation queue, plus hand sequences for reset and ignored starts.
module tb_pheap_level_engine;
  localparam int LEVEL = 2, LEVELS = 3, KEY_W = 16, VAL_W = 16;
  localparam int KV_W = 32, ENT_W = 36;
  localparam logic [1:0] FREE = 0, LENQ = 1, LDEQ = 2, LREPL = 3;
  localparam logic [1:0] D_IDLE = 0, D_BUSY = 1, D_DONE = 2, D_NEXT = 3;

  logic              clk = 0, rst = 1, start = 0;
  logic [1:0]        op = 0;
  logic [KV_W-1:0]   din = 0;
  logic [0:0]        startPos = 0;
  logic [ENT_W-1:0]  rTop = 0, rBotL = 0, rBotR = 0;
  logic [0:0]        raddrTop, raddrBot, wraddrTop;
  logic              wenTop, active;
  logic [ENT_W-1:0]  wData;
  logic [1:0]        done;
  logic [KV_W-1:0]   dout;
  logic [1:0]        endPos;

  pheap_level_engine #(.LEVEL(LEVEL), .LEVELS(LEVELS), .KEY_W(KEY_W), .VAL_W(VAL_W)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .in(din), .startPos(startPos),
    .rTop(rTop), .rBotL(rBotL), .rBotR(rBotR), .raddrTop(raddrTop), .raddrBot(raddrBot),
    .wenTop(wenTop), .wraddrTop(wraddrTop), .wData(wData), .active(active),
    .done(done), .out(dout), .endPos(endPos));

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]       op;
    logic [KV_W-1:0]  din;
    logic             pos;
    logic [ENT_W-1:0] top, l, r;
    logic [ENT_W-1:0] wd;
    logic [KV_W-1:0]  out;
    logic [1:0]       ep;
    logic [1:0]       dn;
  } vec_t;

  vec_t vecs[$];
  vec_t exp_q[$];
  int nvec = 0, nerr = 0;

  function automatic logic [ENT_W-1:0] mk(input logic v, input logic [2:0] c,
                                          input logic [15:0] k, input logic [15:0] d);
    return {v, c, k, d};
  endfunction

  function automatic vec_t mv(input logic [1:0] o, input logic [31:0] i, input logic p,
      input logic [35:0] t, input logic [35:0] l, input logic [35:0] r,
      input logic [35:0] wd, input logic [31:0] ou, input logic [1:0] ep, input logic [1:0] dn);
    vec_t v;
    v.op = o; v.din = i; v.pos = p; v.top = t; v.l = l; v.r = r;
    v.wd = wd; v.out = ou; v.ep = ep; v.dn = dn;
    return v;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    vec_t e;
    bit got;
    @(negedge clk);
    start = 1; op = v.op; din = v.din; startPos = v.pos;
    exp_q.push_back(v);
    @(negedge clk);
    start = 0; rTop = v.top; rBotL = v.l; rBotR = v.r;
    chk("rd_active", 64'(active), 64'd1);
    chk("rd_done", 64'(done), 64'(D_BUSY));
    chk("raddrTop", 64'(raddrTop), 64'(v.pos));
    chk("raddrBot", 64'(raddrBot), 64'(v.pos));
    got = 0;
    for (int i = 0; i < 4 && !got; i++) begin
      @(negedge clk);
      if (wenTop) got = 1;
    end
    e = exp_q.pop_front();
    if (!got) begin
      nvec++; nerr++;
      $display("FAIL wen_timeout: no wenTop within 4 cycles");
    end else begin
      chk("wraddrTop", 64'(wraddrTop), 64'(e.pos));
      chk("wData", 64'(wData), 64'(e.wd));
      chk("out", 64'(dout), 64'(e.out));
      chk("wr_done", 64'(done), 64'(e.dn));
      if (e.dn == D_NEXT) chk("endPos", 64'(endPos), 64'(e.ep));
    end
    @(negedge clk);
    chk("post_done", 64'(done), 64'(D_DONE));
    chk("post_wen", 64'(wenTop), 64'd0);
  endtask

  initial begin
    // LENQ
    vecs.push_back(mv(LENQ, 32'h0010_00AA, 1, 36'd0, 36'd0, 36'd0,
                      mk(1,0,16'h10,16'hAA), 32'd0, 2'd0, D_DONE));
    vecs.push_back(mv(LENQ, 32'h0010_0011, 1, mk(1,0,16'h20,16'hBB), 36'd0, 36'd0,
                      mk(1,1,16'h10,16'h11), 32'h0020_00BB, 2'd2, D_NEXT));
    vecs.push_back(mv(LENQ, 32'h0030_0033, 1, mk(1,1,16'h20,16'hBB), mk(1,0,16'h40,16'h1), 36'd0,
                      mk(1,2,16'h20,16'hBB), 32'h0030_0033, 2'd3, D_NEXT));
    vecs.push_back(mv(LENQ, 32'h0005_0001, 0, mk(1,2,16'h20,16'hBB), mk(1,0,16'h40,16'h1),
                      mk(1,0,16'h50,16'h2), mk(1,2,16'h20,16'hBB), 32'd0, 2'd0, D_DONE));
    vecs.push_back(mv(LENQ, 32'h0020_0099, 1, mk(1,0,16'h20,16'hBB), 36'd0, 36'd0,
                      mk(1,1,16'h20,16'hBB), 32'h0020_0099, 2'd2, D_NEXT));
    // LDEQ
    vecs.push_back(mv(LDEQ, 32'd0, 1, mk(1,2,16'h20,16'hBB), mk(1,0,16'h30,16'hC),
                      mk(1,0,16'h25,16'hD), mk(1,1,16'h25,16'hD), 32'd0, 2'd3, D_NEXT));
    vecs.push_back(mv(LDEQ, 32'd0, 1, mk(1,0,16'h20,16'hBB), 36'd0, 36'd0,
                      36'd0, 32'd0, 2'd0, D_DONE));
    vecs.push_back(mv(LDEQ, 32'd0, 0, mk(1,2,16'h10,16'h1), mk(1,0,16'h30,16'hA),
                      mk(1,0,16'h30,16'hB), mk(1,1,16'h30,16'hA), 32'd0, 2'd0, D_NEXT));
    vecs.push_back(mv(LDEQ, 32'd0, 0, mk(1,1,16'h10,16'h1), 36'd0,
                      mk(1,0,16'h50,16'hE), mk(1,0,16'h50,16'hE), 32'd0, 2'd1, D_NEXT));
    // LREPL
    vecs.push_back(mv(LREPL, 32'h0040_0044, 1, mk(1,1,16'h20,16'hBB), mk(1,0,16'h30,16'hC), 36'd0,
                      mk(1,1,16'h30,16'hC), 32'h0040_0044, 2'd2, D_NEXT));
    vecs.push_back(mv(LREPL, 32'h0005_0055, 1, mk(1,1,16'h20,16'hBB), mk(1,0,16'h30,16'hC), 36'd0,
                      mk(1,1,16'h05,16'h55), 32'd0, 2'd0, D_DONE));
    vecs.push_back(mv(LREPL, 32'h0030_0077, 0, mk(1,1,16'h20,16'hBB), mk(1,0,16'h30,16'hC), 36'd0,
                      mk(1,1,16'h30,16'h77), 32'd0, 2'd0, D_DONE));
    vecs.push_back(mv(LREPL, 32'hFFFF_0001, 0, mk(1,2,16'h20,16'hBB), mk(1,0,16'h90,16'hC),
                      mk(1,0,16'h80,16'hD), mk(1,2,16'h80,16'hD), 32'hFFFF_0001, 2'd1, D_NEXT));

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_active", 64'(active), 64'd0);
    chk("rst_wen", 64'(wenTop), 64'd0);
    chk("rst_done", 64'(done), 64'(D_IDLE));
    chk("rst_outs", 64'({wData, raddrTop, raddrBot, wraddrTop}), 64'd0);
    chk("rst_out", 64'({dout, endPos}), 64'd0);
    rst = 0;

    // Reset during READ aborts without a write
    @(negedge clk);
    start = 1; op = LENQ; din = 32'h0010_00AA; startPos = 1;
    @(negedge clk);
    start = 0;
    chk("abort_rd_active", 64'(active), 64'd1);
    rst = 1;
    @(negedge clk);
    rst = 0;
    chk("abort_active", 64'(active), 64'd0);
    chk("abort_wen", 64'(wenTop), 64'd0);
    chk("abort_done", 64'(done), 64'(D_IDLE));
    @(negedge clk);
    chk("abort_wen2", 64'(wenTop), 64'd0);

    foreach (vecs[i]) run(vecs[i]);

    // FREE is ignored; done keeps DONE
    @(negedge clk);
    start = 1; op = FREE; din = 32'h1234_5678;
    @(negedge clk);
    start = 0;
    chk("free_active", 64'(active), 64'd0);
    chk("free_done", 64'(done), 64'(D_DONE));

    // start while in READ is ignored
    @(negedge clk);
    start = 1; op = LENQ; din = 32'h0010_00AA; startPos = 1;
    @(negedge clk);
    op = LDEQ; rTop = 36'd0; rBotL = 36'd0; rBotR = 36'd0;
    @(negedge clk);
    start = 0;
    chk("ign_wen", 64'(wenTop), 64'd1);
    chk("ign_wData", 64'(wData), 64'(mk(1,0,16'h10,16'hAA)));
    @(negedge clk);
    chk("ign_active", 64'(active), 64'd0);
    chk("ign_done", 64'(done), 64'(D_DONE));
    @(negedge clk);
    chk("ign_active2", 64'(active), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/pheap_level_engine.md
Name:
pheap_level_engine

Overview:
- Per-level operation engine for a pipelined min-heap priority queue (P-heap). Smaller key means higher priority.
- One instance serves one heap level LEVEL (2..LEVELS). It reads one node of its own level plus that node's two children in the level below.
- It performs one step of enqueue, dequeue or replace, writes the node back, and either finishes or hands the operation to the next level.
- The level RAMs are external and synchronous-read. A parent controller pipelines operations through successive engines.

Parameters:
- LEVEL, 2, heap level served (root = 1; the root uses a separate engine).
- LEVELS, 4, total heap levels; capacity is 2^LEVELS-1.
- KEY_W, 16, priority key width.
- VAL_W, 16, payload width.
- Derived: KV_W = KEY_W+VAL_W; CNT_W = LEVELS; ENT_W = 1+CNT_W+KV_W.
- Entry layout, MSB first: valid | cnt | key | value. cnt = number of occupied descendants of the node.
- An all-zero entry is an empty node.

Ports:
- clk in 1: clock; all logic on rising edge.
- rst in 1: synchronous, active-high reset.
- start in 1: one-cycle request pulse.
- op in 2: FREE=0, LENQ=1, LDEQ=2, LREPL=3; sampled with start.
- in in KV_W: incoming {key,value}; sampled with start.
- startPos in LEVEL-1: node index within this level; sampled with start.
- rTop in ENT_W: RAM read data for the node.
- rBotL in ENT_W: read data for the left child; all-zero when LEVEL==LEVELS.
- rBotR in ENT_W: read data for the right child; all-zero when LEVEL==LEVELS.
- raddrTop out LEVEL-1: node read address.
- raddrBot out LEVEL-1: parent index handed to the lower level RAM; that RAM returns both children {p,0} and {p,1}.
- wenTop out 1: node write enable.
- wraddrTop out LEVEL-1: node write address.
- wData out ENT_W: node write data.
- active out 1: engine owns this level's RAM.
- done out 2: IDLE=0, BUSY=1, DONE=2, NEXT_LEVEL=3.
- out out KV_W: item passed to the next level.
- endPos out LEVEL: child index for the next level, {startPos, dir}; dir 0 = left.

Behaviour:
- Reset: state IDLE. active=0, wenTop=0, done=IDLE, and out, endPos, wData, raddrTop, raddrBot, wraddrTop all 0.
- Reset mid-operation aborts the operation with no write.
- FSM: IDLE → READ → WRITE → IDLE.
  - start=1 with op≠FREE, in IDLE (done IDLE or DONE), latches op, in and startPos and goes to READ.
  - start in any other state is ignored. op=FREE is ignored.
- READ (T+1): active=1, done=BUSY, raddrTop=raddrBot=startPos. rTop, rBotL and rBotR are valid in the next cycle.
- WRITE (T+2): active=1, wenTop=1, wraddrTop=startPos. wData, out, endPos and done are derived combinationally from the RAM data. Next state is IDLE.
- After WRITE, done holds DONE until the next start. NEXT_LEVEL lasts exactly one cycle. active=0 outside READ and WRITE.
- Child subtree size S = 2^(LEVELS-LEVEL)-1; occ(child) = valid + cnt.
- LENQ:
  - If the node is empty, write {1,0,in}; done=DONE.
  - Otherwise, if in.key < top.key, keep in and out=top.kv; else keep top.kv and out=in. Ties keep top.
  - dir = 0 if occ(L) < S, else 1. Write cnt+1. done=NEXT_LEVEL; the parent forwards op LENQ.
  - If both children are full (upstream error), write the node unchanged and done=DONE; the item is dropped.
- LDEQ:
  - If neither child is valid, write all-zero; done=DONE.
  - Otherwise pick the valid child with the smaller key (tie or right invalid → left). Write {1,cnt-1,child.kv}; dir = that child; done=NEXT_LEVEL. out = 0 (ignored downstream).
- LREPL (node is always valid):
  - If no valid child has key < in.key, write {1,cnt,in}; done=DONE.
  - Otherwise pick the smaller valid child as in LDEQ. Write {1,cnt,child.kv}; out=in; dir = that child; done=NEXT_LEVEL.
- Out-of-range values: cnt never exceeds 2S. Key compares are unsigned.
- No RAM bypass is performed; the controller guarantees read/write ordering.

Test Plan:
LEVEL=2, LEVELS=3 (S=1). All stimulus follows a synchronous reset.
1. Reset with clk running → all outputs 0, done=IDLE. Assert rst during READ → returns IDLE, no wenTop.
2. LENQ in=0x0010_00AA, startPos=1, rTop=0 → T+1 raddrTop=1, done=BUSY. T+2 wenTop=1, wraddrTop=1, wData={1,0,0x0010,0x00AA}, done=DONE, held afterwards.
3. LENQ in key 0x0010, rTop {1,0,0x0020,0x0BB}, children empty → wData key 0x0010 cnt=1, out=0x0020_00BB, endPos=2, done=NEXT_LEVEL for one cycle then DONE.
4. LENQ key 0x0030, rTop {1,1,0x0020}, rBotL valid cnt0 → out=in, endPos=3, wData cnt=2 key 0x0020.
5. LDEQ rTop {1,2,0x0020}, L key 0x0030, R key 0x0025 → wData {1,1,0x0025..}, endPos=3, NEXT_LEVEL. LDEQ with both children empty → wData=0, DONE.
6. LREPL key 0x0040, rTop key 0x0020 cnt1, L key 0x0030, R empty → wData key 0x0030 cnt1, out=in, endPos=2, NEXT_LEVEL. LREPL key 0x0005 → wData key 0x0005, DONE. start during READ is ignored.
